// File: rtl/z80_bus_bridge.sv
// Z80 pin-side bus responder: turns each qualified core bus cycle into one req/ack back-end
// transaction, stretching the cycle with wait_n and answering interrupt acknowledge locally.
module z80_bus_bridge #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] z80_addr,
    input  logic [7:0]  z80_dout,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  z80_din,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StInta} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  din_q, din_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;

    logic memrd, memwr, iord, iowr, inta, active;
    logic keep_result;

    assign memrd  = ~mreq_n & ~rd_n & rfsh_n;
    assign memwr  = ~mreq_n & ~wr_n;
    assign iord   = ~iorq_n & ~rd_n & m1_n;
    assign iowr   = ~iorq_n & ~wr_n & m1_n;
    assign inta   = ~iorq_n & ~m1_n;
    assign active = memrd | memwr | iord | iowr | inta;

    // A result is only delivered if the core is still waiting for it.
    assign keep_result = active & ~abort_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        we_d    = we_q;
        io_d    = io_q;
        err_d   = err_q;
        abort_d = abort_q;

        case (state_q)
            StIdle: begin
                if (active) begin
                    if (inta) begin
                        din_d   = INT_VECTOR;
                        state_d = StInta;
                    end else begin
                        addr_d  = z80_addr;
                        wdata_d = z80_dout;
                        we_d    = memwr | iowr;
                        io_d    = iord | iowr;
                        req_d   = 1'b1;
                        cnt_d   = 8'h00;
                        abort_d = 1'b0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (!active) begin
                    abort_d = 1'b1;
                end
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (keep_result) begin
                        din_d   = mem_rdata;
                        state_d = StHold;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (keep_result) begin
                        din_d   = 8'hFF;
                        state_d = StHold;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold, StInta: begin
                if (!active) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'h00;
            din_q   <= 8'h00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign z80_din     = din_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_io      = io_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign timeout_err = err_q;

    // Held high during reset so the core is never stalled by a bridge that is being cleared.
    assign wait_n = wb_rst_i |
                    ~(active & ((state_q == StIdle) | (state_q == StReq)) & ~inta);

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Scoreboarded bench for z80_bus_bridge: request attributes are queued when a cycle is driven
// and checked when mem_req rises; per-scenario tasks check timing and returned data.
module tb_z80_bus_bridge;

    localparam int K_RD    = 0;
    localparam int K_WR    = 1;
    localparam int K_IORD  = 2;
    localparam int K_IOWR  = 3;
    localparam int K_FETCH = 4;
    localparam int K_INTA  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] z80_addr = 16'h0000;
    logic [7:0]  z80_dout = 8'h00;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic [7:0]  z80_din;
    logic        wait_n, mem_req, mem_we, mem_io, timeout_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic        io;
        logic [7:0]  wdata;
    } req_t;

    req_t exp_q[$];
    logic req_prev = 1'b0;
    int   req_rises = 0;
    int   req_hi_cnt = 0;

    always #5 clk = ~clk;

    z80_bus_bridge #(.TIMEOUT(4), .INT_VECTOR(8'hFF)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .z80_addr   (z80_addr),
        .z80_dout   (z80_dout),
        .m1_n       (m1_n),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .rfsh_n     (rfsh_n),
        .z80_din    (z80_din),
        .wait_n     (wait_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_io     (mem_io),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    // Request monitor: pops the scoreboard on every mem_req rising edge.
    always @(negedge clk) begin
        req_t e;
        if (mem_req === 1'b1) req_hi_cnt++;
        if (mem_req === 1'b1 && req_prev === 1'b0) begin
            req_rises++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_req: got addr=%h we=%b io=%b, required no request",
                         mem_addr, mem_we, mem_io);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_we, mem_io, mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL req_attr: got addr=%h we=%b io=%b wdata=%h, required addr=%h we=%b io=%b wdata=%h",
                             mem_addr, mem_we, mem_io, mem_wdata, e.addr, e.we, e.io, e.wdata);
                end
            end
        end
        req_prev = mem_req;
    end

    task automatic set_idle();
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
    endtask

    task automatic drive_kind(input int kind);
        set_idle();
        case (kind)
            K_RD:    begin mreq_n = 1'b0; rd_n = 1'b0; end
            K_WR:    begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_FETCH: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            K_INTA:  begin m1_n = 1'b0; iorq_n = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic push_exp(input int kind, input logic [15:0] addr, input logic [7:0] dout);
        req_t e;
        e.addr  = addr;
        e.we    = (kind == K_WR) || (kind == K_IOWR);
        e.io    = (kind == K_IORD) || (kind == K_IOWR);
        e.wdata = dout;
        exp_q.push_back(e);
    endtask

    // Starts at posedge+1 in IDLE, returns at posedge+1 in IDLE after the strobes drop.
    // ack_lat = k acks in the k-th request cycle; 0 never acks.
    task automatic run_access(input int kind, input logic [15:0] addr, input logic [7:0] dout,
                              input int ack_lat, input logic [7:0] rdata,
                              output int wait_lo, output int req_hi,
                              output logic [7:0] din, output logic wait_after);
        int reqcyc;
        z80_addr = addr;
        z80_dout = dout;
        if (kind != K_INTA) push_exp(kind, addr, dout);
        req_hi_cnt = 0;
        reqcyc     = 0;
        wait_lo    = 0;
        drive_kind(kind);
        #1;
        while (!wait_n && wait_lo < 64) begin
            wait_lo++;
            if (mem_req) begin
                reqcyc++;
                if (reqcyc == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            #1;
        end
        @(posedge clk); #1;
        din        = z80_din;
        wait_after = wait_n;
        req_hi     = req_hi_cnt;
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({z80_din, wait_n, mem_req, mem_we, mem_io, mem_addr, mem_wdata, timeout_err} !==
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_in: got din=%h wait_n=%b req=%b we=%b io=%b addr=%h wdata=%h err=%b, required reset values",
                     z80_din, wait_n, mem_req, mem_we, mem_io, mem_addr, mem_wdata, timeout_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({z80_din, wait_n, mem_req, mem_addr, timeout_err} !==
            {8'h00, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_out: got din=%h wait_n=%b req=%b addr=%h err=%b, required 00/1/0/0000/0",
                     z80_din, wait_n, mem_req, mem_addr, timeout_err);
        end
    endtask

    task automatic test_mem_read();
        int wl, rh, r0;
        logic [7:0] d;
        logic wa;
        r0 = req_rises;
        run_access(K_RD, 16'h1234, 8'h00, 3, 8'hA5, wl, rh, d, wa);
        vectors++;
        if (wl !== 4) begin miscompares++; $display("FAIL rd_wait: got %0d cycles, required 4", wl); end
        vectors++;
        if (rh !== 3) begin miscompares++; $display("FAIL rd_req_len: got %0d, required 3", rh); end
        vectors++;
        if (d !== 8'hA5 || wa !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_hold: got din=%h wait_n=%b, required A5/1", d, wa);
        end
        vectors++;
        if (z80_din !== 8'hA5 || req_rises - r0 !== 1) begin
            miscompares++;
            $display("FAIL rd_idle: got din=%h reqs=%0d, required A5/1", z80_din, req_rises - r0);
        end
    endtask

    task automatic test_write_io();
        int wl, rh, r0;
        logic [7:0] d;
        logic wa;
        r0 = req_rises;
        run_access(K_WR, 16'h8000, 8'h3C, 1, 8'h00, wl, rh, d, wa);
        vectors++;
        if (wl !== 2 || rh !== 1) begin
            miscompares++;
            $display("FAIL wr_timing: got wait=%0d req=%0d, required 2/1", wl, rh);
        end
        run_access(K_IOWR, 16'h00FE, 8'h55, 2, 8'h00, wl, rh, d, wa);
        vectors++;
        if (wl !== 3 || rh !== 2) begin
            miscompares++;
            $display("FAIL iowr_timing: got wait=%0d req=%0d, required 3/2", wl, rh);
        end
        vectors++;
        if ({mem_we, mem_io, mem_wdata, mem_addr} !== {1'b1, 1'b1, 8'h55, 16'h00FE} ||
            req_rises - r0 !== 2) begin
            miscompares++;
            $display("FAIL iowr_latch: got we=%b io=%b wdata=%h addr=%h reqs=%0d, required 1/1/55/00FE/2",
                     mem_we, mem_io, mem_wdata, mem_addr, req_rises - r0);
        end
    endtask

    task automatic test_inta();
        int wl, rh, r0;
        logic [7:0] d;
        logic wa;
        r0 = req_rises;
        run_access(K_INTA, 16'h0038, 8'h00, 0, 8'h00, wl, rh, d, wa);
        vectors++;
        if (wl !== 0 || rh !== 0 || req_rises - r0 !== 0) begin
            miscompares++;
            $display("FAIL inta_bus: got wait=%0d req=%0d reqs=%0d, required 0/0/0", wl, rh, req_rises - r0);
        end
        vectors++;
        if (d !== 8'hFF || z80_din !== 8'hFF) begin
            miscompares++;
            $display("FAIL inta_vec: got %h/%h, required FF", d, z80_din);
        end
    endtask

    task automatic test_fetch_refresh();
        int wl, rh, r0;
        logic [7:0] d;
        logic wa;
        r0 = req_rises;
        run_access(K_FETCH, 16'h0100, 8'h00, 1, 8'h3E, wl, rh, d, wa);
        vectors++;
        if (wl !== 2 || d !== 8'h3E) begin
            miscompares++;
            $display("FAIL fetch: got wait=%0d din=%h, required 2/3E", wl, d);
        end
        z80_addr = 16'h0042;
        mreq_n   = 1'b0;
        rfsh_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({wait_n, mem_req} !== 2'b10) begin
                miscompares++;
                $display("FAIL refresh: got wait_n=%b req=%b, required 1/0", wait_n, mem_req);
            end
            @(posedge clk); #1;
        end
        set_idle();
        @(posedge clk); #1;
        vectors++;
        if (req_rises - r0 !== 1 || z80_din !== 8'h3E) begin
            miscompares++;
            $display("FAIL refresh_reqs: got reqs=%0d din=%h, required 1/3E", req_rises - r0, z80_din);
        end
    endtask

    task automatic test_timeout();
        int wl, rh;
        logic [7:0] d;
        logic wa;
        run_access(K_RD, 16'h0300, 8'h00, 0, 8'h00, wl, rh, d, wa);
        vectors++;
        if (wl !== 5 || rh !== 4) begin
            miscompares++;
            $display("FAIL to_timing: got wait=%0d req=%0d, required 5/4", wl, rh);
        end
        vectors++;
        if (d !== 8'hFF || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_result: got din=%h err=%b, required FF/1", d, timeout_err);
        end
        run_access(K_WR, 16'h0400, 8'h11, 2, 8'h00, wl, rh, d, wa);
        vectors++;
        if (wl !== 3 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_sticky_wr: got wait=%0d err=%b, required 3/1", wl, timeout_err);
        end
        run_access(K_RD, 16'h0500, 8'h00, 1, 8'h77, wl, rh, d, wa);
        vectors++;
        if (d !== 8'h77 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_sticky_rd: got din=%h err=%b, required 77/1", d, timeout_err);
        end
    endtask

    task automatic test_reset_in_req();
        int wl, rh;
        logic [7:0] d;
        logic wa;
        z80_addr = 16'h4000;
        z80_dout = 8'h00;
        push_exp(K_RD, 16'h4000, 8'h00);
        drive_kind(K_RD);
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_req_up: got req=%b, required 1", mem_req);
        end
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_req_drop: got req=%b, required 0", mem_req);
        end
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'hC3;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        #1;
        vectors++;
        if ({z80_din, wait_n, mem_req, mem_we, mem_io, mem_addr, mem_wdata, timeout_err} !==
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_late_ack: got din=%h wait_n=%b req=%b we=%b io=%b addr=%h wdata=%h err=%b, required reset values",
                     z80_din, wait_n, mem_req, mem_we, mem_io, mem_addr, mem_wdata, timeout_err);
        end
        @(posedge clk); #1;
        run_access(K_RD, 16'h2222, 8'h00, 1, 8'h99, wl, rh, d, wa);
        vectors++;
        if (wl !== 2 || rh !== 1 || d !== 8'h99 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_next_rd: got wait=%0d req=%0d din=%h err=%b, required 2/1/99/0",
                     wl, rh, d, timeout_err);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_mem_read();
        test_write_io();
        test_inta();
        test_fetch_refresh();
        test_timeout();
        test_reset_in_req();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending requests, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
